score_draw_ctrl: RTL

Sequencer that renders a binary game score onto the 160x120 VGA framebuffer using the digit-glyph ROM reader. On `start` it latches the score and converts it to BCD with a sequential double-dabble. It then walks every pixel of every digit glyph, driving `id/i/j` into the glyph reader and emitting `x/y/colour/plot` to the VGA adapter one ROM latency later. It sits between game-state logic (the requester) and the shared VGA plot port.

---
 rtl/score_draw_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/score_draw_ctrl.sv
// Renders a latched binary score as NUM_DIGITS glyphs on the VGA plot port.
// The score is converted to BCD, then every glyph pixel is read and plotted one ROM latency later.
module score_draw_ctrl #(
   parameter int         NUM_DIGITS    = 4,
   parameter logic [7:0] X0            = 8'd0,
   parameter logic [6:0] Y0            = 7'd0,
   parameter bit         BLANK_LEADING = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [13:0] score,
   output logic        busy,
   output logic        done,
   output logic [4:0]  glyph_id,
   output logic [3:0]  glyph_i,
   output logic [6:0]  glyph_j,
   input  logic [14:0] glyph_colour,
   output logic [7:0]  vga_x,
   output logic [6:0]  vga_y,
   output logic [2:0]  vga_colour,
   output logic        plot
);

   localparam int            DW     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [DW-1:0] D_LAST = DW'(NUM_DIGITS - 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_CONVERT = 3'd1;
   localparam logic [2:0] S_DRAW    = 3'd2;
   localparam logic [2:0] S_FLUSH   = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   logic [2:0]    r_state;
   logic [3:0]    r_cnt;
   logic [29:0]   r_dd;
   logic [DW-1:0] r_d;
   logic [4:0]    r_j;
   logic [3:0]    r_i;
   logic          r_plot;
   logic [7:0]    r_x;
   logic [6:0]    r_y;
   logic          r_blank;

   logic [29:0]   w_dd_adj;
   logic [29:0]   w_dd_shift;
   logic [15:0]   w_bcd;
   logic [3:0]    w_digit;
   logic          w_blank;
   logic [7:0]    w_x;
   logic [6:0]    w_y;
   logic          w_draw;
   logic          w_unused;

   // {BCD[15:0], binary[13:0]}; after 14 shifts the binary half is empty.
   assign w_bcd = r_dd[29:14];

   always_comb begin
      w_dd_adj = r_dd;
      for (int k = 0; k < 4; k++) begin
         if (r_dd[14+4*k +: 4] >= 4'd5)
            w_dd_adj[14+4*k +: 4] = r_dd[14+4*k +: 4] + 4'd3;
      end
      w_dd_shift = {w_dd_adj[28:0], 1'b0};
   end

   // Digit 0 is the most significant; digits beyond the 4 BCD nibbles read as 0.
   always_comb begin
      logic [15:0] v_sh;
      logic [3:0]  v_nib;
      w_digit = 4'd0;
      w_blank = BLANK_LEADING;
      v_sh    = 16'd0;
      v_nib   = 4'd0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         v_sh  = w_bcd >> (4 * (NUM_DIGITS - 1 - k));
         v_nib = v_sh[3:0];
         if (DW'(k) == r_d)
            w_digit = v_nib;
         if ((k <= int'(r_d)) && (v_nib != 4'd0))
            w_blank = 1'b0;
      end
      if (r_d == D_LAST)
         w_blank = 1'b0;
   end

   assign w_draw = (r_state == S_DRAW);
   assign w_x    = X0 + 8'({r_d, 4'b0000}) + {4'b0000, r_i};
   assign w_y    = Y0 + {2'b00, r_j};

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_dd    <= 30'd0;
         r_d     <= '0;
         r_j     <= 5'd0;
         r_i     <= 4'd0;
         r_plot  <= 1'b0;
         r_x     <= 8'd0;
         r_y     <= 7'd0;
         r_blank <= 1'b0;
      end else begin
         r_plot  <= w_draw;
         r_x     <= w_draw ? w_x : 8'd0;
         r_y     <= w_draw ? w_y : 7'd0;
         r_blank <= w_draw & w_blank;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_dd    <= {16'd0, (score > 14'd9999) ? 14'd9999 : score};
                  r_cnt   <= 4'd0;
                  r_state <= S_CONVERT;
               end
            end
            S_CONVERT: begin
               r_dd  <= w_dd_shift;
               r_cnt <= r_cnt + 4'd1;
               if (r_cnt == 4'd13)
                  r_state <= S_DRAW;
            end
            S_DRAW: begin
               r_i <= r_i + 4'd1;
               if (r_i == 4'd15) begin
                  r_j <= r_j + 5'd1;
                  if (r_j == 5'd31) begin
                     if (r_d == D_LAST) begin
                        r_d     <= '0;
                        r_state <= S_FLUSH;
                     end else begin
                        r_d <= r_d + 1'b1;
                     end
                  end
               end
            end
            S_FLUSH: r_state <= S_DONE;
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy       = (r_state == S_CONVERT) || (r_state == S_DRAW) || (r_state == S_FLUSH);
   assign done       = (r_state == S_DONE);
   assign glyph_id   = w_draw ? {1'b0, w_digit} : 5'd0;
   assign glyph_i    = r_i;
   assign glyph_j    = {2'b00, r_j};
   assign plot       = r_plot;
   assign vga_x      = r_x;
   assign vga_y      = r_y;
   assign vga_colour = (r_plot && !r_blank) ? glyph_colour[2:0] : 3'b000;
   assign w_unused   = ^glyph_colour[14:3];

endmodule
